// File: rtl/addsub_result_buf_pkg.sv
// Shared constants and types for the add/sub result buffer.
// Holds flag bit positions, flag vector width and the 16-bit saturation limits.
// Imported by addsub_flag_gen and addsub_result_buf.
package addsub_result_buf_pkg;

   localparam int FLAG_V   = 0;
   localparam int FLAG_C   = 1;
   localparam int FLAG_Z   = 2;
   localparam int FLAG_N   = 3;
   localparam int FLAG_SUB = 4;
   localparam int FLAG_W   = 5;

   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   // Field order matches the bit indices above: sub is bit 4, v is bit 0.
   typedef struct packed {
      logic sub;
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/addsub_flag_gen.sv
// Flag generation for one adder result: optional saturation, then {SUB,N,Z,C,V}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only uses the outputs when it pushes.
// Saturation is enabled by defining ADDSUB_RESULT_SAT_EN.
module addsub_flag_gen
   import addsub_result_buf_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]      sum,
   input  logic              cout,
   input  logic              ovf,
   input  logic              sub,
   output logic [W-1:0]      sum_out,
   output logic [FLAG_W-1:0] flags
);

`ifdef ADDSUB_RESULT_SAT_EN
   // Width-generic forms of SAT_POS / SAT_NEG (identical to them at W=16).
   localparam logic [W-1:0] SAT_P = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_N = {1'b1, {(W-1){1'b0}}};

   // A wrapped negative result means the true value overflowed upwards, and vice versa.
   always_comb begin
      sum_out = sum;
      if (ovf) begin
         sum_out = sum[W-1] ? SAT_P : SAT_N;
      end
   end
`else
   // Without saturation the two's-complement wrapped value is kept as is.
   always_comb begin
      sum_out = sum;
   end
`endif

   // N and Z describe the value actually stored; C and V pass through untouched.
   always_comb begin
      flags           = '0;
      flags[FLAG_SUB] = sub;
      flags[FLAG_N]   = sum_out[W-1];
      flags[FLAG_Z]   = (sum_out == '0);
      flags[FLAG_C]   = cout;
      flags[FLAG_V]   = ovf;
   end

endmodule

// File: rtl/addsub_result_buf.sv
// Registered result FIFO behind the add/sub datapath with flags and sticky overflow.
// Latency: an entry pushed at edge k is presented from cycle k+1; no in-to-out bypass.
// Backpressure: in_ready = !full, and a same-cycle pop never frees a slot for a push when full.
// Optional saturation of overflowed sums is built when ADDSUB_RESULT_SAT_EN is defined.
module addsub_result_buf
   import addsub_result_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_sum,
   input  logic                     in_cout,
   input  logic                     in_ovf,
   input  logic                     in_sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_sum,
   output logic [FLAG_W-1:0]        out_flags,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf_sticky,
   input  logic                     clr_sticky
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  sum_mem  [DEPTH];
   flags_t        flag_mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [W-1:0]      gen_sum;
   logic [FLAG_W-1:0] gen_flags;
   logic              push;
   logic              pop;
   logic              empty;

   addsub_flag_gen #(
      .W (W)
   ) u_flag_gen (
      .sum     (in_sum),
      .cout    (in_cout),
      .ovf     (in_ovf),
      .sub     (in_sub),
      .sum_out (gen_sum),
      .flags   (gen_flags)
   );

   // Handshake qualifiers; push depends only on full, so a pop cannot refill a full buffer.
   always_comb begin
      empty     = (count == '0);
      in_ready  = (count != FULL_CNT);
      out_valid = !empty;
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   // Head outputs are forced to zero when empty so stale storage never leaks out.
   always_comb begin
      out_sum   = '0;
      out_flags = '0;
      if (!empty) begin
         out_sum   = sum_mem[rd_ptr];
         out_flags = flag_mem[rd_ptr];
      end
   end

   // Entry storage is not reset; count decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         sum_mem[wr_ptr]  <= gen_sum;
         flag_mem[wr_ptr] <= flags_t'(gen_flags);
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: an accepted V=1 entry takes priority over a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (push && in_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_result_buf.sv
// Randomized and directed bench for addsub_result_buf against a queue-based model.
// The model applies the buffer rules directly: bounded FIFO, flags from the stored value.
// Honours ADDSUB_RESULT_SAT_EN the same way the design does.
module tb_addsub_result_buf;

   localparam int DEPTH = 4;
   localparam int W     = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_sum = '0;
   logic          in_cout = 1'b0;
   logic          in_ovf = 1'b0;
   logic          in_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_sum;
   logic [4:0]    out_flags;
   logic [CW-1:0] count;
   logic          ovf_sticky;
   logic          clr_sticky = 1'b0;

   int vectors    = 0;
   int miscompares = 0;

   // Model state: entries are {flags[4:0], sum[W-1:0]}.
   logic [W+4:0] q[$];
   logic         m_sticky = 1'b0;
   logic [W+4:0] exp_head;

   always #5 clk = ~clk;

   addsub_result_buf #(.DEPTH(DEPTH), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_cout    (in_cout),
      .in_ovf     (in_ovf),
      .in_sub     (in_sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_flags  (out_flags),
      .count      (count),
      .ovf_sticky (ovf_sticky),
      .clr_sticky (clr_sticky)
   );

   // Expected stored entry from the flag rules.
   function automatic logic [W+4:0] expect_entry(input logic [W-1:0] s, input logic c,
                                                 input logic o, input logic sb);
      logic [W-1:0] st;
      logic n, z;
      st = s;
`ifdef ADDSUB_RESULT_SAT_EN
      if (o) st = ($signed(s) < 0) ? 16'h7FFF : 16'h8000;
`endif
      n = ($signed(st) < 0);
      z = (st == 0);
      return {sb, n, z, c, o, st};
   endfunction

   function automatic logic [W+4:0] model_head();
      return (q.size() > 0) ? q[0] : '0;
   endfunction

   // Advance one clock with the currently driven inputs and update the model.
   task automatic step();
      bit push, pop;
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(expect_entry(in_sum, in_cout, in_ovf, in_sub));
      if (push && in_ovf) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] s, input logic c,
                        input logic o, input logic sb, input logic rdy);
      in_valid = v; in_sum = s; in_cout = c; in_ovf = o; in_sub = sb; out_ready = rdy;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 0 ||
          out_flags !== 0 || ovf_sticky !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: cnt=%0d ov=%b ir=%b sum=%h fl=%b st=%b, want 0 0 1 0000 00000 0",
                  count, out_valid, in_ready, out_sum, out_flags, ovf_sticky);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_push();
      drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0005 || out_flags !== 5'b00000 || count !== 1) begin
         miscompares++;
         $display("FAIL single_push: ov=%b sum=%h fl=%b cnt=%0d, want 1 0005 00000 1",
                  out_valid, out_sum, out_flags, count);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (count !== 0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pop: cnt=%0d ov=%b, want 0 0", count, out_valid);
      end
   endtask

   task automatic test_sub_zero();
      drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_flags !== 5'b10110) begin
         miscompares++;
         $display("FAIL sub_zero: ov=%b sum=%h fl=%b, want 1 0000 10110", out_valid, out_sum, out_flags);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (count !== 0 || out_valid !== 1'b0 || out_sum !== 0 || out_flags !== 0) begin
         miscompares++;
         $display("FAIL sub_zero_pop: cnt=%0d ov=%b sum=%h fl=%b, want 0 0 0000 00000",
                  count, out_valid, out_sum, out_flags);
      end
   endtask

   task automatic test_fill_hold();
      // Two fills so the second one exercises pointer wrap.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, W'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
            step();
         end
         // Fifth offer while full and not draining: must be refused.
         drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
         exp_head = model_head();
         vectors++;
         if (count !== DEPTH || in_ready !== 1'b0 || {out_flags, out_sum} !== exp_head) begin
            miscompares++;
            $display("FAIL fill_hold: cnt=%0d ir=%b head=%h, want %0d 0 %h",
                     count, in_ready, {out_flags, out_sum}, DEPTH, exp_head);
         end
         // Full with a pop: no same-cycle refill, so occupancy drops.
         drive(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b1);
         step();
         vectors++;
         if (count !== DEPTH - 1 || q.size() != DEPTH - 1) begin
            miscompares++;
            $display("FAIL full_pop_no_refill: cnt=%0d, want %0d", count, DEPTH - 1);
         end
         in_valid = 1'b0;
         while (q.size() > 0) begin
            exp_head = model_head();
            vectors++;
            if (out_valid !== 1'b1 || {out_flags, out_sum} !== exp_head) begin
               miscompares++;
               $display("FAIL fill_drain: ov=%b head=%h, want 1 %h", out_valid, {out_flags, out_sum}, exp_head);
            end
            step();
         end
         out_ready = 1'b0;
      end
   endtask

   task automatic test_concurrent();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, W'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         exp_head = model_head();
         drive(1'b1, W'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b1);
         vectors++;
         if ({out_flags, out_sum} !== exp_head) begin
            miscompares++;
            $display("FAIL concurrent_order: head=%h, want %h", {out_flags, out_sum}, exp_head);
         end
         step();
         vectors++;
         if (count !== 2) begin
            miscompares++;
            $display("FAIL concurrent_count: cnt=%0d, want 2", count);
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      drive(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      exp_head = model_head();
      vectors++;
`ifdef ADDSUB_RESULT_SAT_EN
      if (out_sum !== 16'h7FFF || out_flags[3] !== 1'b0 || out_flags[0] !== 1'b1 ||
`else
      if (out_sum !== 16'h8000 || out_flags[3] !== 1'b1 || out_flags[0] !== 1'b1 ||
`endif
          {out_flags, out_sum} !== exp_head || ovf_sticky !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow: head=%h st=%b, want %h 1", {out_flags, out_sum}, ovf_sticky, exp_head);
      end
      // Clear and a V=1 push in the same cycle: set wins.
      drive(1'b1, 16'h7FFE, 1'b1, 1'b1, 1'b1, 1'b0);
      clr_sticky = 1'b1;
      step();
      in_valid = 1'b0;
      vectors++;
      if (ovf_sticky !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_set_wins: st=%b, want 1", ovf_sticky);
      end
      step();
      clr_sticky = 1'b0;
      vectors++;
      if (ovf_sticky !== 1'b0) begin
         miscompares++;
         $display("FAIL sticky_clear: st=%b, want 0", ovf_sticky);
      end
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom),
               1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
         clr_sticky = 1'($urandom_range(0, 9) == 0);
         step();
         exp_head = model_head();
         vectors++;
         if (count !== CW'(q.size()) || out_valid !== (q.size() > 0) ||
             in_ready !== (q.size() < DEPTH) || {out_flags, out_sum} !== exp_head ||
             ovf_sticky !== m_sticky) begin
            miscompares++;
            $display("FAIL random[%0d]: cnt=%0d head=%h st=%b ir=%b, want %0d %h %b %b", i, count,
                     {out_flags, out_sum}, ovf_sticky, in_ready, q.size(), exp_head, m_sticky, q.size() < DEPTH);
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      clr_sticky = 1'b0;
      for (int i = 0; i < DEPTH; i++) step();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W'($urandom), 1'b0, (i == 1), 1'b0, 1'b0);
         step();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_sticky !== 1'b0 ||
          out_sum !== 0 || out_flags !== 0) begin
         miscompares++;
         $display("FAIL async_reset: cnt=%0d ov=%b ir=%b st=%b, want 0 0 1 0",
                  count, out_valid, in_ready, ovf_sticky);
      end
      q.delete();
      m_sticky = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      vectors++;
      if (count !== 1 || out_sum !== 16'h1234) begin
         miscompares++;
         $display("FAIL post_reset_push: cnt=%0d sum=%h, want 1 1234", count, out_sum);
      end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_sub_zero();
      test_fill_hold();
      test_concurrent();
      test_overflow();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
